// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, controller states,
// divider constants and the signed-result fixup helper.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } mdu_state_e;

  localparam int          DIV_ITERS = 32;
  localparam logic [31:0] DIV0_LO   = 32'hFFFF_FFFF;

  // Two's-complement negate when neg is set; the magnitude 0x80000000 maps to itself.
  function automatic logic [31:0] apply_sign(input logic [31:0] mag, input logic neg);
    return neg ? (~mag + 32'd1) : mag;
  endfunction

endpackage

// File: rtl/div_iter.sv
// 32-bit unsigned restoring divider, one quotient bit per cycle.
// done is high during the cycle that performs the final iteration.
module div_iter
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        abort,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dsor_q, dsor_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        run_q, run_d;
  logic [32:0] part, diff;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    quot_d = quot_q;
    rem_d  = rem_q;
    dsor_d = dsor_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    part   = {rem_q, quot_q[31]};
    diff   = part - {1'b0, dsor_q};
    if (start) begin
      quot_d = dividend;
      rem_d  = '0;
      dsor_d = divisor;
      cnt_d  = '0;
      run_d  = 1'b1;
    end else if (run_q) begin
      // A clear borrow bit means the trial subtraction fits: keep it and shift in a 1.
      if (!diff[32]) begin
        rem_d  = diff[31:0];
        quot_d = {quot_q[30:0], 1'b1};
      end else begin
        rem_d  = part[31:0];
        quot_d = {quot_q[30:0], 1'b0};
      end
      cnt_d = cnt_q + 6'd1;
      if (cnt_q == 6'(DIV_ITERS - 1)) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst || abort) begin
      quot_q <= '0;
      rem_q  <= '0;
      dsor_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
    end else begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dsor_q <= dsor_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
    end
  end

  assign done = run_q && (cnt_q == 6'(DIV_ITERS - 1));
  assign quot = quot_q;
  assign rem  = rem_q;

endmodule

// File: rtl/mdu_hilo_ctrl.sv
// Multiply/divide sequencer owning the HI/LO pair; stalls EX while busy.
// Define MDU_HILO_BYPASS_EN to forward the value being written onto hilo_o.
module mdu_hilo_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        stall_o,
  output logic        busy_o,
  output logic [63:0] hilo_o
);

  mdu_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] hilo_q, hilo_d;
  logic [63:0] prod_q, prod_d;
  logic        isdiv_q, isdiv_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;

  logic        is_signed;
  logic [63:0] mul_a, mul_b, mul_full;
  logic [31:0] dvd_mag, dsr_mag;
  logic        div_start, div_done;
  logic [31:0] div_quot, div_rem;
  logic [63:0] result;

  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  // 33-bit sign/zero extension carried into a 64-bit multiply; the low 64 bits are exact.
  assign mul_a    = {{31{is_signed & rs_val[31]}}, is_signed & rs_val[31], rs_val};
  assign mul_b    = {{31{is_signed & rt_val[31]}}, is_signed & rt_val[31], rt_val};
  assign mul_full = mul_a * mul_b;
  assign dvd_mag  = apply_sign(rs_val, is_signed & rs_val[31]);
  assign dsr_mag  = apply_sign(rt_val, is_signed & rt_val[31]);
  assign result   = isdiv_q ? {apply_sign(div_rem, rneg_q), apply_sign(div_quot, qneg_q)}
                            : prod_q;

  div_iter u_div_iter (
    .clk      (clk),
    .rst      (rst),
    .abort    (flush),
    .start    (div_start),
    .dividend (dvd_mag),
    .divisor  (dsr_mag),
    .done     (div_done),
    .quot     (div_quot),
    .rem      (div_rem)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hilo_d    = hilo_q;
    prod_d    = prod_q;
    isdiv_d   = isdiv_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    div_start = 1'b0;
    stall_o   = 1'b0;
    unique case (state_q)
      S_IDLE: if (op_valid && !flush) begin
        case (op)
          OP_MTHI: hilo_d[63:32] = rs_val;
          OP_MTLO: hilo_d[31:0]  = rs_val;
          OP_MULT, OP_MULTU: begin
            stall_o = 1'b1;
            prod_d  = mul_full;
            isdiv_d = 1'b0;
            cnt_d   = '0;
            state_d = S_MUL;
          end
          OP_DIV, OP_DIVU: begin
            stall_o = 1'b1;
            if (rt_val == 32'd0) begin
              // Divide-by-zero result is known now; reuse the product path.
              prod_d  = {rs_val, DIV0_LO};
              isdiv_d = 1'b0;
              state_d = S_DONE;
            end else begin
              div_start = 1'b1;
              isdiv_d   = 1'b1;
              qneg_d    = is_signed & (rs_val[31] ^ rt_val[31]);
              rneg_d    = is_signed & rs_val[31];
              state_d   = S_DIV;
            end
          end
          default: ;
        endcase
      end
      S_MUL: begin
        stall_o = 1'b1;
        if (cnt_q == 4'(MUL_LAT - 1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DIV: begin
        stall_o = 1'b1;
        if (div_done) state_d = S_DONE;
      end
      S_DONE: begin
        hilo_d  = result;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      hilo_d    = hilo_q;
      div_start = 1'b0;
      stall_o   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hilo_q  <= '0;
      prod_q  <= '0;
      isdiv_q <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hilo_q  <= hilo_d;
      prod_q  <= prod_d;
      isdiv_q <= isdiv_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign busy_o = (state_q != S_IDLE);

`ifdef MDU_HILO_BYPASS_EN
  assign hilo_o = hilo_d;
`else
  assign hilo_o = hilo_q;
`endif

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// Scoreboard bench for mdu_hilo_ctrl: expected stall length and HI/LO are
// queued at issue and compared once the unit returns to IDLE.
module tb_mdu_hilo_ctrl;
  import mdu_pkg::*;

  localparam int MUL_LAT = 4;

  logic        clk = 1'b0;
  logic        rst, flush, op_valid;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        stall_o, busy_o;
  logic [63:0] hilo_o;

  always #5 clk = ~clk;

  mdu_hilo_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .op_valid (op_valid),
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .hilo_o   (hilo_o)
  );

  typedef struct {
    string       tag;
    int          stall;
    logic [63:0] hilo;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] model_hilo;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] cur);
    longint sa, sb_, q, r;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    case (o)
      OP_MTHI:  return {a, cur[31:0]};
      OP_MTLO:  return {cur[63:32], a};
      OP_MULT:  return 64'(sa * sb_);
      OP_MULTU: return {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb_;
        r = sa % sb_;
        return {r[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return cur;
    endcase
  endfunction

  function automatic int exp_stall(input logic [2:0] o, input logic [31:0] b);
    case (o)
      OP_MULT, OP_MULTU: return MUL_LAT + 1;
      OP_DIV, OP_DIVU:   return (b == 32'd0) ? 1 : DIV_ITERS + 1;
      default:           return 0;
    endcase
  endfunction

  // Hold the op while stalled, drop it after the closing edge, then score.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    exp_t e, got_e;
    int   n;
    e.tag   = tag;
    e.hilo  = model(o, a, b, model_hilo);
    e.stall = exp_stall(o, b);
    model_hilo = e.hilo;
    sb.push_back(e);
    @(posedge clk); #1;
    op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
    n = 0;
    #1;
    while (stall_o === 1'b1 && n < 100) begin
      n++;
      @(posedge clk); #2;
    end
    @(posedge clk); #1;
    op_valid = 1'b0;
    #1;
    got_e = sb.pop_front();
    check({got_e.tag, " stall"}, 64'(n), 64'(got_e.stall));
    check({got_e.tag, " hilo"}, hilo_o, got_e.hilo);
    check({got_e.tag, " busy"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    int          n;
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;

    rst = 1'b1; flush = 1'b0; op_valid = 1'b0; op = '0; rs_val = '0; rt_val = '0;
    model_hilo = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset hilo", hilo_o, 64'd0);
    check("reset stall", 64'(stall_o), 64'd0);
    check("reset busy", 64'(busy_o), 64'd0);

    issue(OP_MULT,  32'hFFFF_FFFD, 32'd5, "mult");
    issue(OP_MULTU, 32'hFFFF_FFFD, 32'd5, "multu");
    issue(OP_DIVU,  32'd100, 32'd7, "divu 100/7");
    issue(OP_DIV,   32'hFFFF_FFF9, 32'd2, "div -7/2");
    issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div ovf");
    issue(OP_DIVU,  32'h0000_1234, 32'd0, "divu by 0");

    // Back-to-back MTHI/MTLO.
    @(posedge clk); #1;
    op_valid = 1'b1; op = OP_MTHI; rs_val = 32'hDEAD_BEEF;
    #1;
    check("mthi stall", 64'(stall_o), 64'd0);
`ifdef MDU_HILO_BYPASS_EN
    check("mthi bypass", hilo_o, {32'hDEAD_BEEF, model_hilo[31:0]});
`else
    check("mthi hold", hilo_o, model_hilo);
`endif
    @(posedge clk); #1;
    op = OP_MTLO; rs_val = 32'h0000_0001;
    #1;
    check("mtlo stall", 64'(stall_o), 64'd0);
`ifdef MDU_HILO_BYPASS_EN
    check("mtlo bypass", hilo_o, 64'hDEAD_BEEF_0000_0001);
`else
    check("mtlo hold", hilo_o, {32'hDEAD_BEEF, model_hilo[31:0]});
`endif
    @(posedge clk); #1;
    op_valid = 1'b0;
    #1;
    model_hilo = 64'hDEAD_BEEF_0000_0001;
    check("mthi/mtlo hilo", hilo_o, model_hilo);

    // Flush at T10 of a divide, then MTLO at T11.
    @(posedge clk); #1;
    op_valid = 1'b1; op = OP_DIV; rs_val = 32'd1000; rt_val = 32'd3;
    repeat (10) begin @(posedge clk); #1; end
    #1;
    check("div T10 stall", 64'(stall_o), 64'd1);
    check("div T10 busy", 64'(busy_o), 64'd1);
    flush = 1'b1;
    #1;
    check("flush cycle stall", 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; op = OP_MTLO; rs_val = 32'h0000_00A5;
    #1;
    check("T11 busy", 64'(busy_o), 64'd0);
    check("T11 stall", 64'(stall_o), 64'd0);
`ifdef MDU_HILO_BYPASS_EN
    check("T11 bypass", hilo_o, {model_hilo[63:32], 32'h0000_00A5});
`else
    check("T11 hilo", hilo_o, model_hilo);
`endif
    @(posedge clk); #1;
    op_valid = 1'b0;
    #1;
    model_hilo = {model_hilo[63:32], 32'h0000_00A5};
    check("mtlo after flush", hilo_o, model_hilo);

    // Flush in DONE must suppress the write.
    @(posedge clk); #1;
    op_valid = 1'b1; op = OP_MULT; rs_val = 32'd7; rt_val = 32'd9;
    n = 0;
    #1;
    while (stall_o === 1'b1 && n < 100) begin
      n++;
      @(posedge clk); #2;
    end
    check("done-flush stall", 64'(n), 64'(MUL_LAT + 1));
    flush = 1'b1; op_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    check("done-flush hilo", hilo_o, model_hilo);
    check("done-flush busy", 64'(busy_o), 64'd0);

    // Reset mid-multiply.
    @(posedge clk); #1;
    op_valid = 1'b1; op = OP_MULT; rs_val = 32'd9; rt_val = 32'd9;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1; op_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    model_hilo = '0;
    check("rst hilo", hilo_o, 64'd0);
    check("rst stall", 64'(stall_o), 64'd0);
    check("rst busy", 64'(busy_o), 64'd0);
    issue(OP_MULT, 32'd2, 32'd3, "mult after rst");

    for (int i = 0; i < 12; i++) begin
      r_op = 3'($urandom_range(0, 5));
      r_a  = $urandom;
      r_b  = ($urandom_range(0, 7) == 0) ? 32'd0 :
             ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      issue(r_op, r_a, r_b, $sformatf("rand%0d op%0d", i, r_op));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
